axi4_traffic_master: RTL and testbench

//  AXI4 initiator for the DDR3 system bench. Drives the AXI4 slave port of the DDR3 controller top.
//  On start: writes NUM_BURSTS INCR bursts of a known pattern from BASE_ADDR, then reads them back and compares.

---
 rtl/axi_tg_pkg.sv | 27 ++
 rtl/axi_tg_pattern.sv | 67 ++++++
 rtl/axi4_traffic_master.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_axi4_traffic_master.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tg_pkg.sv
// Shared types and constants for the AXI4 traffic master.
// The LFSR constant is only consumed when AXI_TG_LFSR_EN is defined.
package axi_tg_pkg;

    // Top-level sequencing states for the write-then-read-back pass
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } tg_state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One step of the right-shifting Galois LFSR
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        lfsr_step = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/axi_tg_pattern.sv
// Data pattern generator for the traffic master; one copy per direction.
// AXI_TG_LFSR_EN defined  : 32-bit Galois LFSR seeded with SEED, stepped on each accepted beat.
// AXI_TG_LFSR_EN undefined: beat byte address XOR SEED (purely combinational).
// The 32-bit pattern is truncated or replicated to fill DATA_W.
module axi_tg_pattern
    import axi_tg_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [31:0] SEED   = 32'hA5A5_0F0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              advance,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [31:0] pattern;

`ifdef AXI_TG_LFSR_EN

    logic [31:0] lfsr_q;
    logic        unused_addr;

    // The address only drives the pattern in the address-XOR mode
    assign unused_addr = ^addr;

    // Reload the seed at every phase start and step once per accepted beat
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            lfsr_q <= SEED;
        end else if (advance) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign pattern = lfsr_q;

`else

    logic [31:0] addr32;
    logic        unused_ctrl;

    // No state is kept in this mode, so the sequencing inputs are not needed
    assign unused_ctrl = ^{clk, rst, restart, advance, addr};

    // Zero-extend or truncate the beat address to the 32-bit pattern width
    for (genvar i = 0; i < 32; i++) begin : g_addr32
        if (i < ADDR_W) begin : g_bit
            assign addr32[i] = addr[i];
        end else begin : g_zero
            assign addr32[i] = 1'b0;
        end
    end

    assign pattern = addr32 ^ SEED;

`endif

    // Replicate the 32-bit pattern across the data bus (truncates when DATA_W < 32)
    for (genvar j = 0; j < DATA_W; j++) begin : g_fit
        assign data[j] = pattern[j % 32];
    end

endmodule

// File: rtl/axi4_traffic_master.sv
// AXI4 initiator for DDR3 bring-up: writes NUM_BURSTS INCR bursts of a known
// pattern from BASE_ADDR, reads them back, and counts mismatches/response errors.
// One burst outstanding at a time; AW always precedes W.
// Optional feature: define AXI_TG_LFSR_EN to use an LFSR data pattern instead of
// the default address-XOR-seed pattern (selected inside axi_tg_pattern).
module axi4_traffic_master
    import axi_tg_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                ID_W       = 4,
    parameter int                BURST_LEN  = 16,
    parameter int                NUM_BURSTS = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ID_W-1:0]   TXN_ID     = 4'h1,
    parameter logic [31:0]       SEED       = 32'hA5A5_0F0F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic [ADDR_W-1:0]     first_err_addr,
    // write address channel
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [ID_W-1:0]       awid,
    output logic [7:0]            awlen,
    output logic [1:0]            awburst,
    // write data channel
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    // write response channel
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    // read address channel
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [ID_W-1:0]       arid,
    output logic [7:0]            arlen,
    output logic [1:0]            arburst,
    // read data channel
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [ID_W-1:0]       rid,
    input  logic [1:0]            rresp,
    input  logic                  rlast
);

    localparam int                 BYTES       = DATA_W / 8;
    localparam logic [7:0]         LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam int                 BURST_CNT_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BURST_CNT_W-1:0] LAST_BURST = BURST_CNT_W'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0]  BEAT_BYTES  = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0]  BURST_BYTES = ADDR_W'(BURST_LEN * BYTES);

    tg_state_e                state_q;
    tg_state_e                state_d;

    logic [7:0]               beat_q;
    logic [BURST_CNT_W-1:0]   burst_q;
    logic [ADDR_W-1:0]        burst_addr_q;
    logic [ADDR_W-1:0]        beat_addr;
    logic [15:0]              err_cnt_q;
    logic [ADDR_W-1:0]        first_err_q;

    logic                     start_acc;
    logic                     last_beat;
    logic                     last_burst;
    logic                     aw_hs;
    logic                     w_hs;
    logic                     b_hs;
    logic                     ar_hs;
    logic                     r_hs;
    logic                     b_err;
    logic                     r_err;
    logic                     err_event;
    logic [ADDR_W-1:0]        err_addr;
    logic                     rd_restart;
    logic [DATA_W-1:0]        wr_pattern;
    logic [DATA_W-1:0]        rd_expect;

    // Handshakes and beat/burst position; valids come from state only, never from a ready
    assign start_acc  = (state_q == IDLE) && start;
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == LAST_BURST);
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign b_hs       = bvalid && bready;
    assign ar_hs      = arvalid && arready;
    assign r_hs       = rvalid && rready;
    assign beat_addr  = burst_addr_q + (ADDR_W'(beat_q) * BEAT_BYTES);
    assign rd_restart = b_hs && last_burst;

    // Response checking: several faults on one beat still count as a single error
    assign b_err     = b_hs && ((bresp != AXI_RESP_OKAY) || (bid != TXN_ID));
    assign r_err     = r_hs && ((rdata != rd_expect) || (rresp != AXI_RESP_OKAY) ||
                                (rid != TXN_ID) || (rlast != last_beat));
    assign err_event = b_err || r_err;
    assign err_addr  = b_hs ? burst_addr_q : beat_addr;

    // Constant and registered payload; held stable for as long as the state holds
    assign awaddr  = burst_addr_q;
    assign araddr  = burst_addr_q;
    assign awid    = TXN_ID;
    assign arid    = TXN_ID;
    assign awlen   = LAST_BEAT;
    assign arlen   = LAST_BEAT;
    assign awburst = AXI_BURST_INCR;
    assign arburst = AXI_BURST_INCR;
    assign wstrb   = '1;
    assign wdata   = wr_pattern;

    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing: write all bursts, then read them all back
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = WR_ADDR;
            end
            WR_ADDR: begin
                if (aw_hs) state_d = WR_DATA;
            end
            WR_DATA: begin
                if (w_hs && last_beat) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) state_d = last_burst ? RD_ADDR : WR_ADDR;
            end
            RD_ADDR: begin
                if (ar_hs) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (r_hs && last_beat) state_d = last_burst ? DONE : RD_ADDR;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channel valids/readies and status decoded purely from the current state
    always_comb begin
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            WR_ADDR: begin
                awvalid = 1'b1;
                busy    = 1'b1;
            end
            WR_DATA: begin
                wvalid = 1'b1;
                wlast  = last_beat;
                busy   = 1'b1;
            end
            WR_RESP: begin
                bready = 1'b1;
                busy   = 1'b1;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                busy    = 1'b1;
            end
            RD_DATA: begin
                rready = 1'b1;
                busy   = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Beat and burst position; the beat counter is shared by both phases
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q       <= '0;
            burst_q      <= '0;
            burst_addr_q <= '0;
        end else begin
            if (start_acc) begin
                beat_q       <= '0;
                burst_q      <= '0;
                burst_addr_q <= BASE_ADDR;
            end else begin
                if (w_hs || r_hs) begin
                    beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
                end
                if (b_hs || (r_hs && last_beat)) begin
                    if (last_burst) begin
                        burst_q      <= '0;
                        burst_addr_q <= BASE_ADDR;
                    end else begin
                        burst_q      <= burst_q + BURST_CNT_W'(1);
                        burst_addr_q <= burst_addr_q + BURST_BYTES;
                    end
                end
            end
        end
    end

    // Saturating error count with the address of the first error since start
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else if (start_acc) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else if (err_event) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (err_cnt_q == 16'd0) begin
                first_err_q <= err_addr;
            end
        end
    end

    axi_tg_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_wr_pattern (
        .clk     (clk),
        .rst     (rst),
        .restart (start_acc),
        .advance (w_hs),
        .addr    (beat_addr),
        .data    (wr_pattern)
    );

    axi_tg_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_rd_pattern (
        .clk     (clk),
        .rst     (rst),
        .restart (rd_restart),
        .advance (r_hs),
        .addr    (beat_addr),
        .data    (rd_expect)
    );

endmodule

// File: tb/tb_axi4_traffic_master.sv
// Scoreboard bench for axi4_traffic_master with a behavioural AXI slave.
// Three bursts of four beats are used so that the beat at BASE_ADDR+0x24 exists.
// Pattern model follows AXI_TG_LFSR_EN the same way the design does.
module tb_axi4_traffic_master;

    localparam int          ADDR_W      = 32;
    localparam int          DATA_W      = 32;
    localparam int          ID_W        = 4;
    localparam int          BURST_LEN   = 4;
    localparam int          NUM_BURSTS  = 3;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_1000;
    localparam logic [3:0]  TXN_ID      = 4'h1;
    localparam logic [31:0] SEED        = 32'hA5A5_0F0F;
    localparam int          TOTAL_BEATS = BURST_LEN * NUM_BURSTS;
    localparam logic [31:0] CORRUPT_ADDR = BASE_ADDR + 32'h24;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [15:0]       err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [1:0]        awburst;
    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [1:0]        arburst;
    logic              rvalid, rready;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic              rlast;

    logic bp_en;
    logic corrupt_en;
    logic bresp_err_en;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } wbeat_t;

    typedef struct {
        logic [15:0] err;
        logic [31:0] addr;
    } result_t;

    wbeat_t      exp_w[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_ar[$];
    result_t     exp_res[$];

    axi4_traffic_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .BURST_LEN  (BURST_LEN),
        .NUM_BURSTS (NUM_BURSTS),
        .BASE_ADDR  (BASE_ADDR),
        .TXN_ID     (TXN_ID),
        .SEED       (SEED)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .awvalid        (awvalid),
        .awready        (awready),
        .awaddr         (awaddr),
        .awid           (awid),
        .awlen          (awlen),
        .awburst        (awburst),
        .wvalid         (wvalid),
        .wready         (wready),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wlast          (wlast),
        .bvalid         (bvalid),
        .bready         (bready),
        .bid            (bid),
        .bresp          (bresp),
        .arvalid        (arvalid),
        .arready        (arready),
        .araddr         (araddr),
        .arid           (arid),
        .arlen          (arlen),
        .arburst        (arburst),
        .rvalid         (rvalid),
        .rready         (rready),
        .rdata          (rdata),
        .rid            (rid),
        .rresp          (rresp),
        .rlast          (rlast)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record one comparison and report it when it does not hold
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // A handshake or pulse that the scoreboard had no entry for
    task automatic reportUnexpected(input string name);
        check_count++;
        $display("[TB] FAIL %s: got an event, expected none", name);
    endtask

    // Expected data for beat idx counted from the start of a phase
    function automatic logic [31:0] modelPattern(input int idx);
        logic [31:0] s;
`ifdef AXI_TG_LFSR_EN
        s = SEED;
        for (int i = 0; i < idx; i++) begin
            s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        end
`else
        s = (BASE_ADDR + 32'(idx * 4)) ^ SEED;
`endif
        return s;
    endfunction

    // Behavioural AXI slave: memory-backed, optional back-pressure and fault injection
    initial begin : slave
        logic [31:0] mem [0:63];
        logic        s_aw, s_w, s_b, s_ar, s_r, c_wlast;
        logic [31:0] c_awaddr, c_wdata, c_araddr, wr_addr, rd_addr;
        logic [7:0]  c_arlen;
        int          rd_left, cur_burst;
        logic        b_pend;
        wr_addr = '0; rd_addr = '0; rd_left = 0; cur_burst = 0; b_pend = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bid = TXN_ID; bresp = 2'b00;
        rvalid = 1'b0; rdata = '0; rid = TXN_ID; rresp = 2'b00; rlast = 1'b0;
        forever begin
            @(negedge clk);
            s_aw = awvalid && awready; c_awaddr = awaddr;
            s_w  = wvalid && wready;   c_wdata = wdata; c_wlast = wlast;
            s_b  = bvalid && bready;
            s_ar = arvalid && arready; c_araddr = araddr; c_arlen = arlen;
            s_r  = rvalid && rready;
            @(posedge clk);
            #1;
            if (rst) begin
                b_pend = 1'b0; rd_left = 0; cur_burst = 0;
            end else begin
                if (s_aw) begin
                    wr_addr   = c_awaddr;
                    cur_burst = int'((c_awaddr - BASE_ADDR) / (BURST_LEN * 4));
                end
                if (s_w) begin
                    mem[int'((wr_addr - BASE_ADDR) >> 2) & 63] = c_wdata;
                    wr_addr = wr_addr + 32'd4;
                    if (c_wlast) b_pend = 1'b1;
                end
                if (s_b) b_pend = 1'b0;
                if (s_ar) begin
                    rd_addr = c_araddr;
                    rd_left = int'(c_arlen) + 1;
                end
                if (s_r) begin
                    rd_addr = rd_addr + 32'd4;
                    rd_left--;
                end
            end
            awready = !rst && (!bp_en || $urandom_range(0, 9) >= 3);
            wready  = !rst && (!bp_en || $urandom_range(0, 9) >= 3);
            arready = !rst && (!bp_en || $urandom_range(0, 9) >= 3);
            bvalid  = b_pend;
            bresp   = (bresp_err_en && cur_burst == 0) ? 2'b10 : 2'b00;
            rvalid  = (rd_left > 0);
            rlast   = (rd_left == 1);
            rdata   = (rd_left > 0) ? mem[int'((rd_addr - BASE_ADDR) >> 2) & 63] : 32'h0;
            if (corrupt_en && rd_left > 0 && rd_addr == CORRUPT_ADDR) rdata[0] = ~rdata[0];
        end
    end

    // Monitor: pops scoreboard entries on every handshake/done and checks payload hold
    initial begin : monitor
        logic        aw_stall, w_stall, ar_stall, wl_prev;
        logic [31:0] aw_prev, ar_prev, wd_prev, ea;
        wbeat_t      ew;
        result_t     er;
        int          run_r, run_b;
        aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0; run_r = 0; run_b = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0; run_r = 0; run_b = 0;
            end else begin
                if (aw_stall) begin
                    checkOutput("aw_hold_valid", awvalid, 1);
                    checkOutput("aw_hold_addr", awaddr, aw_prev);
                end
                if (w_stall) begin
                    checkOutput("w_hold_valid", wvalid, 1);
                    checkOutput("w_hold_data", {wlast, wdata}, {wl_prev, wd_prev});
                end
                if (ar_stall) begin
                    checkOutput("ar_hold_valid", arvalid, 1);
                    checkOutput("ar_hold_addr", araddr, ar_prev);
                end
                aw_stall = awvalid && !awready; aw_prev = awaddr;
                w_stall  = wvalid && !wready;   wd_prev = wdata; wl_prev = wlast;
                ar_stall = arvalid && !arready; ar_prev = araddr;

                if (awvalid && awready) begin
                    if (exp_aw.size() == 0) reportUnexpected("aw_extra");
                    else begin
                        ea = exp_aw.pop_front();
                        checkOutput("aw_addr", awaddr, ea);
                        checkOutput("aw_ctrl", {awid, awlen, awburst}, {TXN_ID, 8'(BURST_LEN - 1), 2'b01});
                    end
                end
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) reportUnexpected("w_extra");
                    else begin
                        ew = exp_w.pop_front();
                        checkOutput("w_data", wdata, ew.data);
                        checkOutput("w_last", wlast, ew.last);
                        checkOutput("w_strb", wstrb, 4'hF);
                    end
                end
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) reportUnexpected("ar_extra");
                    else begin
                        ea = exp_ar.pop_front();
                        checkOutput("ar_addr", araddr, ea);
                        checkOutput("ar_ctrl", {arid, arlen, arburst}, {TXN_ID, 8'(BURST_LEN - 1), 2'b01});
                    end
                end
                if (bvalid && bready) run_b++;
                if (rvalid && rready) run_r++;
                if (done) begin
                    if (exp_res.size() == 0) reportUnexpected("done_extra");
                    else begin
                        er = exp_res.pop_front();
                        checkOutput("err_cnt", err_cnt, er.err);
                        if (er.err != 16'd0) checkOutput("first_err_addr", first_err_addr, er.addr);
                        checkOutput("r_beats", run_r, TOTAL_BEATS);
                        checkOutput("b_resps", run_b, NUM_BURSTS);
                        checkOutput("w_left", exp_w.size(), 0);
                    end
                    run_r = 0; run_b = 0;
                end
            end
        end
    end

    // Synchronous reset of DUT and slave, dropping any pending expectations
    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_w.delete(); exp_aw.delete(); exp_ar.delete(); exp_res.delete();
        rst = 1'b0;
    endtask

    // Queue one full run's expectations and pulse start
    task automatic applyStimulus(input logic [15:0] exp_err, input logic [31:0] exp_addr);
        wbeat_t  wb;
        result_t r;
        for (int b = 0; b < NUM_BURSTS; b++) begin
            exp_aw.push_back(BASE_ADDR + 32'(b * BURST_LEN * 4));
            exp_ar.push_back(BASE_ADDR + 32'(b * BURST_LEN * 4));
            for (int k = 0; k < BURST_LEN; k++) begin
                wb.data = modelPattern(b * BURST_LEN + k);
                wb.last = (k == BURST_LEN - 1);
                exp_w.push_back(wb);
            end
        end
        r.err  = exp_err;
        r.addr = exp_addr;
        exp_res.push_back(r);
        @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
    endtask

    // Wait (bounded) for the done pulse; recover with a reset if it never arrives
    task automatic waitDone(input int budget);
        int   n;
        logic seen;
        n = 0; seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        checkOutput("done_seen", seen, 1);
        if (!seen) resetDut();
    endtask

    // Directed sequence of runs
    initial begin : stimulus
        int seen_w, guard;
        rst = 1'b1; start = 1'b0; bp_en = 1'b0; corrupt_en = 1'b0; bresp_err_en = 1'b0;
        resetDut();
        checkOutput("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_first_err", first_err_addr, 0);

        $display("[TB] run 1: ideal slave");
        applyStimulus(16'd0, 32'd0);
        waitDone(1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("start_in_done_busy", busy, 0);
        @(negedge clk);
        checkOutput("start_in_done_aw", awvalid, 0);

        $display("[TB] run 2: ready back-pressure, start while busy");
        bp_en = 1'b1;
        applyStimulus(16'd0, 32'd0);
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(3000);
        bp_en = 1'b0;

        $display("[TB] run 3: corrupted read beat");
        corrupt_en = 1'b1;
        applyStimulus(16'd1, CORRUPT_ADDR);
        waitDone(1000);
        corrupt_en = 1'b0;

        $display("[TB] run 4: SLVERR on first write response");
        bresp_err_en = 1'b1;
        applyStimulus(16'd1, BASE_ADDR);
        waitDone(1000);
        bresp_err_en = 1'b0;

        $display("[TB] run 5: reset during write beat 2");
        applyStimulus(16'd0, 32'd0);
        seen_w = 0; guard = 0;
        while (seen_w < 2 && guard < 200) begin
            @(negedge clk);
            if (wvalid && wready) seen_w++;
            guard++;
        end
        checkOutput("mid_beats_seen", seen_w, 2);
        @(negedge clk);
        checkOutput("pre_rst_wvalid", wvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        checkOutput("post_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        exp_w.delete(); exp_aw.delete(); exp_ar.delete(); exp_res.delete();
        rst = 1'b0;

        $display("[TB] run 6: clean run after reset");
        applyStimulus(16'd0, 32'd0);
        waitDone(1000);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Absolute time limit in case a wait escapes its bound
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
